// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one memory port between instruction fetch and load/store; one     |
// | transaction outstanding. Optional byte-enable legality check is enabled  |
// | by defining MEM_ARB_BE_CHECK_EN.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int N          = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [N-1:0]  o_if_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [3:0]    i_d_be,
  input  logic [N-1:0]  i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [N-1:0]  o_d_rdata,
  output logic          o_d_err,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_mem_be,
  output logic [N-1:0]  o_mem_wdata,
  input  logic          i_mem_ready,
  input  logic          i_mem_rvalid,
  input  logic [N-1:0]  i_mem_rdata
);
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;
  localparam logic       OWN_IF       = 1'b0;
  localparam logic       OWN_D        = 1'b1;
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    starve_q, starve_d;
  logic          err_q, err_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [N-1:0]  mem_wdata_q, mem_wdata_d;
  logic          if_win, d_win, be_bad, resp;

`ifdef MEM_ARB_BE_CHECK_EN
  always_comb begin
    case (i_d_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_bad = 1'b0;
      default:                   be_bad = 1'b1;
    endcase
  end
  assign o_d_err = (state_q == ST_WAIT_RESP) && err_q;
`else
  assign be_bad  = 1'b0;
  assign o_d_err = 1'b0;
`endif

  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (state_q == ST_IDLE && i_rst_n) begin
      if (i_if_req && (!i_d_req || starve_q == STARVE_LIMIT)) if_win = 1'b1;
      else if (i_d_req)                                        d_win  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_if_req) starve_d = '0;
        if (if_win) begin
          owner_d     = OWN_IF;
          starve_d    = '0;
          err_d       = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_be_d    = 4'b1111;
          mem_wdata_d = '0;
          state_d     = ST_ISSUE;
        end else if (d_win) begin
          owner_d = OWN_D;
          if (i_if_req && starve_q != STARVE_LIMIT) starve_d = starve_q + 4'd1;
          err_d = be_bad;
          // An illegal pattern never reaches the bus; it completes locally.
          if (be_bad) begin
            state_d = ST_WAIT_RESP;
          end else begin
            mem_we_d    = i_d_we;
            mem_addr_d  = i_d_addr;
            mem_be_d    = i_d_be;
            mem_wdata_d = i_d_wdata;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_mem_ready) state_d = mem_we_q ? ST_IDLE : ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (err_q || i_mem_rvalid) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp        = (state_q == ST_WAIT_RESP) && !err_q && i_mem_rvalid;
    o_mem_req   = (state_q == ST_ISSUE);
    o_if_rvalid = resp && (owner_q == OWN_IF);
    o_if_rdata  = (resp && owner_q == OWN_IF) ? i_mem_rdata : '0;
    o_d_rvalid  = (resp && owner_q == OWN_D) || ((state_q == ST_WAIT_RESP) && err_q);
    o_d_rdata   = (resp && owner_q == OWN_D) ? i_mem_rdata : '0;
  end

  assign o_if_gnt    = if_win;
  assign o_d_gnt     = d_win;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = mem_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Scenario bench for mem_port_arbiter with a response scoreboard.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_if_req, i_d_req, i_d_we, i_mem_ready, i_mem_rvalid;
  logic [31:0] i_if_addr, i_d_addr, i_d_wdata, i_mem_rdata;
  logic [3:0]  i_d_be;
  logic        o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_d_err;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  resp_t exp_r;
  int    n_vec = 0;
  int    n_err = 0;

  localparam logic [9:0] ORDER = 10'b0111101111;  // bit i = 1: grant i goes to data

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_be(i_d_be),
    .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid),
    .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_addr = '0; i_d_req = 0; i_d_we = 0; i_d_addr = '0;
    i_d_be = '0; i_d_wdata = '0; i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
  endtask

  function automatic logic outs_zero();
    return {o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_d_err, o_mem_req, o_mem_we} == 7'b0
        && o_if_rdata == 0 && o_d_rdata == 0 && o_mem_addr == 0 && o_mem_be == 0
        && o_mem_wdata == 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick(); mid();
    n_vec++;
    if (outs_zero() !== 1'b1) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b addr=%h be=%h gnt=%b%b rv=%b%b, want all 0",
               o_mem_req, o_mem_addr, o_mem_be, o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid);
    end
    i_if_req = 1; i_d_req = 1; #1;
    n_vec++;
    if ({o_if_gnt, o_d_gnt} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_no_gnt: got gnt if/d=%b%b, want 00", o_if_gnt, o_d_gnt);
    end
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_fetch_read();
    tick();
    i_if_req = 1; i_if_addr = 32'h100; i_mem_ready = 1;
    mid();
    n_vec++;
    if (o_if_gnt !== 1 || o_d_gnt !== 0 || o_mem_req !== 0) begin
      n_err++;
      $display("FAIL fetch_gnt: got if_gnt=%b d_gnt=%b mem_req=%b, want 1 0 0", o_if_gnt, o_d_gnt, o_mem_req);
    end
    exp_q.push_back('{is_d: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
    tick();
    i_if_req = 0;
    mid();
    n_vec++;
    if (o_mem_req !== 1 || o_mem_we !== 0 || o_mem_addr !== 32'h100 || o_mem_be !== 4'hF) begin
      n_err++;
      $display("FAIL fetch_issue: got req=%b we=%b addr=%h be=%h, want 1 0 00000100 f",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_be);
    end
    tick();
    i_mem_ready = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF;
    mid();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL fetch_resp: scoreboard empty");
    end else begin
      exp_r = exp_q.pop_front();
      if (o_if_rvalid !== 1 || o_d_rvalid !== 0 || o_if_rdata !== exp_r.data || o_d_rdata !== 0) begin
        n_err++;
        $display("FAIL fetch_resp: got if_rv=%b d_rv=%b if_rdata=%h d_rdata=%h, want 1 0 %h 0",
                 o_if_rvalid, o_d_rvalid, o_if_rdata, o_d_rdata, exp_r.data);
      end
    end
    tick();
    i_mem_rvalid = 0;
  endtask

  task automatic test_store_then_load();
    tick();
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h202; i_d_be = 4'b1100; i_d_wdata = 32'hBEEF0000;
    mid();
    n_vec++;
    if (o_d_gnt !== 1 || o_if_gnt !== 0) begin
      n_err++;
      $display("FAIL store_gnt: got d_gnt=%b if_gnt=%b, want 1 0", o_d_gnt, o_if_gnt);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      i_d_req = 0; i_d_we = 0; i_d_addr = '0; i_d_be = '0; i_d_wdata = '0;
      i_mem_ready = (k == 3); i_mem_rvalid = 1; i_mem_rdata = 32'h0BAD0BAD;
      mid();
      n_vec++;
      if (o_mem_req !== 1 || o_mem_we !== 1 || o_mem_addr !== 32'h202 || o_mem_be !== 4'b1100 ||
          o_mem_wdata !== 32'hBEEF0000 || o_d_rvalid !== 0 || o_if_rvalid !== 0) begin
        n_err++;
        $display("FAIL store_hold%0d: got req=%b we=%b addr=%h be=%b wdata=%h rv=%b%b, want 1 1 202 1100 beef0000 00",
                 k, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_if_rvalid, o_d_rvalid);
      end
    end
    tick();
    i_mem_ready = 0; i_mem_rvalid = 0;
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h300; i_d_be = 4'hF;
    mid();
    n_vec++;
    if (o_mem_req !== 0 || o_d_gnt !== 1 || o_d_rvalid !== 0) begin
      n_err++;
      $display("FAIL store_next_gnt: got req=%b d_gnt=%b d_rv=%b, want 0 1 0", o_mem_req, o_d_gnt, o_d_rvalid);
    end
    exp_q.push_back('{is_d: 1'b1, err: 1'b0, data: 32'hCAFEF00D});
    tick();
    i_d_req = 0; i_mem_ready = 1;
    tick();
    i_mem_ready = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D;
    mid();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL load_resp: scoreboard empty");
    end else begin
      exp_r = exp_q.pop_front();
      if (o_d_rvalid !== 1 || o_if_rvalid !== 0 || o_d_rdata !== exp_r.data || o_if_rdata !== 0 || o_d_err !== 0) begin
        n_err++;
        $display("FAIL load_resp: got d_rv=%b if_rv=%b d_rdata=%h if_rdata=%h err=%b, want 1 0 %h 0 0",
                 o_d_rvalid, o_if_rvalid, o_d_rdata, o_if_rdata, o_d_err, exp_r.data);
      end
    end
    tick();
    i_mem_rvalid = 0;
  endtask

  task automatic test_back_to_back();
    int n_gnt = 0;
    int cyc   = 0;
    idle_inputs();
    tick();
    i_if_req = 1; i_if_addr = 32'h400; i_d_req = 1; i_d_we = 0; i_d_addr = 32'h800; i_d_be = 4'hF;
    i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h50000000;
    while (cyc < 60 && (n_gnt < 10 || exp_q.size() != 0)) begin
      mid();
      if (o_if_gnt || o_d_gnt) begin
        n_vec++;
        if (n_gnt >= 10 || (o_if_gnt && o_d_gnt) || o_d_gnt !== ORDER[n_gnt]) begin
          n_err++;
          $display("FAIL b2b_order%0d: got if_gnt=%b d_gnt=%b, want d_gnt=%b", n_gnt, o_if_gnt, o_d_gnt,
                   (n_gnt < 10) ? ORDER[n_gnt] : 1'b0);
        end
        if (n_gnt < 10)
          exp_q.push_back('{is_d: ORDER[n_gnt], err: 1'b0, data: 32'h50000000 + 32'(cyc + 2)});
        n_gnt++;
      end
      if (o_if_rvalid || o_d_rvalid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_resp: unexpected rvalid if/d=%b%b", o_if_rvalid, o_d_rvalid);
        end else begin
          exp_r = exp_q.pop_front();
          if (o_d_rvalid !== exp_r.is_d || o_if_rvalid !== !exp_r.is_d ||
              (exp_r.is_d ? o_d_rdata : o_if_rdata) !== exp_r.data) begin
            n_err++;
            $display("FAIL b2b_resp: got rv if/d=%b%b if_rdata=%h d_rdata=%h, want is_d=%b data=%h",
                     o_if_rvalid, o_d_rvalid, o_if_rdata, o_d_rdata, exp_r.is_d, exp_r.data);
          end
        end
      end
      tick();
      cyc++;
      i_mem_rdata = 32'h50000000 + 32'(cyc);
      if (n_gnt >= 10) begin
        i_if_req = 0; i_d_req = 0;
      end
    end
    if (n_gnt < 10 || exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL b2b_timeout: got %0d grants and %0d pending, want 10 and 0", n_gnt, exp_q.size());
    end
    idle_inputs();
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    i_if_req = 1; i_if_addr = 32'h40; i_mem_ready = 1;
    mid();
    n_vec++;
    if (o_if_gnt !== 1) begin
      n_err++;
      $display("FAIL rstmid_gnt: got %b, want 1", o_if_gnt);
    end
    tick();
    i_if_req = 0;
    tick();
    i_mem_ready = 0;
    mid();
    n_vec++;
    if (o_mem_req !== 0 || o_if_rvalid !== 0 || o_mem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL rstmid_wait: got req=%b rv=%b addr=%h, want 0 0 00000040", o_mem_req, o_if_rvalid, o_mem_addr);
    end
    #1 rst_n = 0;
    #1;
    n_vec++;
    if (outs_zero() !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_clear: got req=%b addr=%h be=%h rv=%b%b, want all 0",
               o_mem_req, o_mem_addr, o_mem_be, o_if_rvalid, o_d_rvalid);
    end
    tick();
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      i_mem_rvalid = 1; i_mem_rdata = 32'h77777777;
      mid();
      n_vec++;
      if (o_if_rvalid !== 0 || o_d_rvalid !== 0 || o_if_rdata !== 0) begin
        n_err++;
        $display("FAIL rstmid_stale%0d: got rv=%b%b rdata=%h, want 0 0 0", k, o_if_rvalid, o_d_rvalid, o_if_rdata);
      end
    end
    tick();
    i_mem_rvalid = 0;
  endtask

  task automatic test_be_check();
    for (int k = 0; k < 2; k++) begin
      tick();
      i_d_req = 1; i_d_we = (k == 1); i_d_addr = 32'h500; i_d_be = (k == 1) ? 4'b0110 : 4'b0101;
      i_d_wdata = 32'h12345678; i_mem_ready = 1;
      mid();
      n_vec++;
      if (o_d_gnt !== 1) begin
        n_err++;
        $display("FAIL be%0d_gnt: got %b, want 1", k, o_d_gnt);
      end
`ifdef MEM_ARB_BE_CHECK_EN
      exp_q.push_back('{is_d: 1'b1, err: 1'b1, data: 32'h0});
      tick();
      i_d_req = 0;
      mid();
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL be%0d_err: scoreboard empty", k);
      end else begin
        exp_r = exp_q.pop_front();
        if (o_mem_req !== 0 || o_d_rvalid !== 1 || o_d_err !== exp_r.err || o_d_rdata !== exp_r.data ||
            o_if_rvalid !== 0) begin
          n_err++;
          $display("FAIL be%0d_err: got req=%b d_rv=%b err=%b rdata=%h, want 0 1 1 0",
                   k, o_mem_req, o_d_rvalid, o_d_err, o_d_rdata);
        end
      end
      tick();
      mid();
      n_vec++;
      if (o_mem_req !== 0 || o_d_rvalid !== 0 || o_d_err !== 0) begin
        n_err++;
        $display("FAIL be%0d_after: got req=%b d_rv=%b err=%b, want 0 0 0", k, o_mem_req, o_d_rvalid, o_d_err);
      end
`else
      tick();
      i_d_req = 0;
      mid();
      n_vec++;
      if (o_mem_req !== 1 || o_mem_be !== ((k == 1) ? 4'b0110 : 4'b0101) || o_mem_we !== (k == 1) || o_d_err !== 0) begin
        n_err++;
        $display("FAIL be%0d_fwd: got req=%b be=%b we=%b err=%b, want 1 %b %b 0",
                 k, o_mem_req, o_mem_be, o_mem_we, o_d_err, (k == 1) ? 4'b0110 : 4'b0101, k == 1);
      end
      if (k == 0) exp_q.push_back('{is_d: 1'b1, err: 1'b0, data: 32'h0B0B0B0B});
      tick();
      i_mem_ready = 0; i_mem_rvalid = (k == 0); i_mem_rdata = 32'h0B0B0B0B;
      mid();
      n_vec++;
      if (k == 0) begin
        exp_r = exp_q.pop_front();
        if (o_d_rvalid !== 1 || o_d_err !== exp_r.err || o_d_rdata !== exp_r.data) begin
          n_err++;
          $display("FAIL be0_load: got d_rv=%b err=%b rdata=%h, want 1 0 %h", o_d_rvalid, o_d_err, o_d_rdata, exp_r.data);
        end
      end else if (o_d_rvalid !== 0 || o_d_err !== 0 || o_mem_req !== 0) begin
        n_err++;
        $display("FAIL be1_store: got d_rv=%b err=%b req=%b, want 0 0 0", o_d_rvalid, o_d_err, o_mem_req);
      end
`endif
      tick();
      idle_inputs();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_fetch_read();
    test_store_then_load();
    test_back_to_back();
    test_reset_mid();
    test_be_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single unified memory port between instruction fetch and the load/store path of the RV32I core. It arbitrates requests from both sides, registers the winning request onto the memory bus, waits out memory wait states, and routes the read response back to the owner. One transaction is outstanding at a time. The data side carries byte enables and store data already lane-aligned by the load/store unit.

## Interface
- `N`, 32: data width.
- `AW`, 32: address width.
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch is waiting; range 1..15.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_if_req` in 1: fetch request.
- `i_if_addr` in AW: fetch address.
- `o_if_gnt` out 1: fetch request accepted.
- `o_if_rvalid` out 1: fetch read data valid.
- `o_if_rdata` out N: fetch read data.
- `i_d_req` in 1: data request.
- `i_d_we` in 1: 1 = store.
- `i_d_addr` in AW: data address.
- `i_d_be` in 4: byte enables.
- `i_d_wdata` in N: store data.
- `o_d_gnt` out 1: data request accepted.
- `o_d_rvalid` out 1: load data valid, or error completion.
- `o_d_rdata` out N: load data.
- `o_d_err` out 1: illegal byte-enable error; see Configuration.
- `o_mem_req` out 1: memory request.
- `o_mem_we` out 1: memory write.
- `o_mem_addr` out AW: memory address.
- `o_mem_be` out 4: memory byte enables.
- `o_mem_wdata` out N: memory write data.
- `i_mem_ready` in 1: memory accepts the request this cycle.
- `i_mem_rvalid` in 1: memory read data valid.
- `i_mem_rdata` in N: memory read data.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT_RESP. An owner register records IF or D.
- **IDLE:** if any request is present, grant exactly one requester, combinationally in the same cycle.
  - Capture the winner's addr/we/be/wdata into the memory-side registers.
  - Go to ISSUE.
  - Fetch requests are captured with we=0 and be=4'b1111.
- **Arbitration:** data wins by default.
  - Fetch wins when the starvation counter equals `STARVE_MAX` and `i_if_req`=1.
  - Counter update at each grant:
    - +1 when data is granted while `i_if_req`=1.
    - Cleared when fetch is granted, or when `i_if_req`=0 in IDLE.
    - Saturates at `STARVE_MAX`.
- **ISSUE:** `o_mem_req`=1 with the registered fields held stable until `i_mem_ready`=1.
  - On acceptance, a write goes to IDLE with no response.
  - On acceptance, a read goes to WAIT_RESP.
- **WAIT_RESP:** on `i_mem_rvalid`=1, pass `i_mem_rdata` combinationally to the owner's rdata and pulse the owner's rvalid for one cycle, then go to IDLE.
  - The non-owner's rvalid stays 0. Both rdata outputs = `i_mem_rdata` whenever their rvalid=1, and 0 otherwise.
- `i_mem_rvalid` outside WAIT_RESP is ignored.
- Requesters must hold request fields until gnt. A requester may drop its request before gnt; nothing is issued.

## Timing
- **Reset:** state IDLE, counter 0, owner IF; all outputs 0, including `o_mem_*`.
- **Reset mid-transaction:** the transaction is abandoned immediately and no rvalid is produced. The memory is responsible for tolerating a dropped request.
- **Read latency:**
  - gnt at cycle T.
  - `o_mem_req` from T+1.
  - Acceptance at T+1 at the earliest.
  - rvalid in the same cycle as `i_mem_rvalid`, at T+2 or later.
- Earliest next gnt is the cycle after rvalid (or after write acceptance), because the FSM returns to IDLE.
- **Simultaneous requests:** see Arbitration; the loser sees gnt=0 and keeps requesting.
- `i_mem_ready` and `i_mem_rvalid` in the same ISSUE cycle: rvalid is not accepted. Memory must return data no earlier than the cycle after acceptance.

## Configuration
- `MEM_ARB_BE_CHECK_EN` defined: a granted data request with `i_d_be` not in {0001, 0010, 0100, 1000, 0011, 1100, 1111} is never issued to memory.
  - The FSM goes IDLE→WAIT_RESP and, on the next cycle, pulses `o_d_rvalid`=1, `o_d_err`=1, `o_d_rdata`=0, then returns to IDLE.
  - This applies to both loads and stores.
- Not defined: no check is made; `o_d_err` is tied to 0 and every byte-enable pattern is forwarded unchanged.

## Test plan
- **Single fetch read:** `i_if_req`, addr 0x100; memory ready immediately, rvalid one cycle later with 0xDEADBEEF → gnt T, `o_mem_req` T+1, `o_if_rvalid`=1 and `o_if_rdata`=0xDEADBEEF at T+2, `o_d_rvalid`=0.
- **SH store at 0x202**, be=1100, wdata=0xBEEF0000, ready delayed 3 cycles → `o_mem_req` held 3+1 cycles with fields stable, no rvalid, next gnt the following cycle.
- **Both ports requesting continuously, `STARVE_MAX`=4** → grant order D,D,D,D,IF,D,D,D,D,IF.
- **Reset asserted during WAIT_RESP** → all outputs 0 immediately; a later `i_mem_rvalid` produces no rvalid.
- **`MEM_ARB_BE_CHECK_EN` defined, data load with be=0101** → `o_mem_req` never asserts; `o_d_rvalid`=`o_d_err`=1 one cycle after gnt. Without the macro, be=0101 is forwarded and `o_d_err` stays 0.
